// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux_scan channel selector.
package mux_scan_pkg;

  // Values of the mode input.
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Dwell counter width; covers the full legal DWELL range (1..255).
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    MANUAL     = 2'd0,
    SCAN_DWELL = 2'd1,
    SCAN_STALL = 2'd2
  } state_e;

endpackage : mux_scan_pkg

// File: rtl/rr_next_ch.sv
// Wrapping priority finder: returns the first enabled channel index at or
// after ptr (inclusive) or strictly after ptr (exclusive), modulo N_CH.
// In exclusive mode the last candidate examined is ptr itself, so a single
// enabled channel maps back onto itself.
module rr_next_ch #(
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  ch_en_i,
  input  logic [SEL_W-1:0] ptr_i,
  input  logic             incl_i,
  output logic [SEL_W-1:0] nxt_o,
  output logic             found_o
);

  int               idx;
  logic [SEL_W-1:0] cand;
  logic             hit;

  // Scan candidates in wrap order and keep the first enabled one.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    nxt_o = ptr_i;
    hit   = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx  = (int'(ptr_i) + i + (incl_i ? 0 : 1)) % N_CH;
      cand = SEL_W'(idx);
      if (!hit && ch_en_i[cand]) begin
        hit   = 1'b1;
        nxt_o = cand;
      end
    end
    found_o = hit;
  end

endmodule : rr_next_ch

// File: rtl/mux_scan.sv
// Registered N-channel selector with manual select and round-robin scan,
// presenting samples on a valid/ready output that tolerates backpressure.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 8,
  parameter int SEL_W = $clog2(N_CH),
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] din,
  input  logic [SEL_W-1:0]  sel,
  input  logic              mode,
  input  logic [N_CH-1:0]   ch_en,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Set while the mask is empty; the first dwell cycle after it refills
  // realigns ptr onto an enabled channel, like a fresh scan entry.
  logic             rearm_q, rearm_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;

  logic             free;
  logic             load;
  logic [W-1:0]     load_data;
  logic [SEL_W-1:0] load_ch;
  logic [SEL_W-1:0] cur_ptr;
  logic [W-1:0]     sel_data, cur_data;
  logic [SEL_W-1:0] entry_nxt, adv_nxt;
  logic             entry_found, adv_found;

  assign free = !out_valid_q || out_ready;

  // Entry alignment: first enabled channel at or after ptr.
  rr_next_ch #(.N_CH(N_CH), .SEL_W(SEL_W)) u_entry (
    .ch_en_i (ch_en),
    .ptr_i   (ptr_q),
    .incl_i  (1'b1),
    .nxt_o   (entry_nxt),
    .found_o (entry_found)
  );

  // Channel the dwell is currently on; realigned only right after an empty mask.
  assign cur_ptr = (state_q == SCAN_DWELL && rearm_q && entry_found) ? entry_nxt : ptr_q;

  // Advance: next enabled channel strictly after the one being sampled.
  rr_next_ch #(.N_CH(N_CH), .SEL_W(SEL_W)) u_adv (
    .ch_en_i (ch_en),
    .ptr_i   (cur_ptr),
    .incl_i  (1'b0),
    .nxt_o   (adv_nxt),
    .found_o (adv_found)
  );

  // Channel muxes; an out-of-range manual select reads as zero.
  always_comb begin
    sel_data = '0;
    cur_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k))     sel_data = din[k*W +: W];
      if (cur_ptr == SEL_W'(k)) cur_data = din[k*W +: W];
    end
  end

  // Next-state logic: mode handling, dwell counting and sample loads.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    rearm_d   = rearm_q;
    load      = 1'b0;
    load_data = '0;
    load_ch   = '0;
    unique case (state_q)
      MANUAL: begin
        if (mode == MODE_SCAN) begin
          state_d = SCAN_DWELL;
          cnt_d   = '0;
          rearm_d = 1'b0;
          if (entry_found) ptr_d = entry_nxt;
        end else if (free) begin
          load      = 1'b1;
          load_data = sel_data;
          load_ch   = sel;
        end
      end
      SCAN_DWELL: begin
        if (mode == MODE_MANUAL) begin
          state_d = MANUAL;
        end else if (ch_en == '0) begin
          cnt_d   = '0;
          rearm_d = 1'b1;
        end else begin
          rearm_d = 1'b0;
          if (cnt_q == CNT_W'(DWELL - 1)) begin
            if (free) begin
              load      = 1'b1;
              load_data = cur_data;
              load_ch   = cur_ptr;
              cnt_d     = '0;
              ptr_d     = adv_found ? adv_nxt : cur_ptr;
            end else begin
              state_d = SCAN_STALL;
              ptr_d   = cur_ptr;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            ptr_d = cur_ptr;
          end
        end
      end
      SCAN_STALL: begin
        if (mode == MODE_MANUAL) begin
          state_d = MANUAL;
        end else if (free) begin
          load      = 1'b1;
          load_data = cur_data;
          load_ch   = cur_ptr;
          cnt_d     = '0;
          ptr_d     = adv_found ? adv_nxt : cur_ptr;
          state_d   = SCAN_DWELL;
        end
      end
      default: state_d = MANUAL;
    endcase
  end

  // Output slot: a load replaces the sample, an accept without load empties it.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_data_d  = load_data;
      out_ch_d    = load_ch;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q     <= MANUAL;
      ptr_q       <= '0;
      cnt_q       <= '0;
      rearm_q     <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      rearm_q     <= rearm_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule : mux_scan

// File: tb/tb_mux_scan.sv
// Directed testbench for mux_scan (N_CH=8, W=8, DWELL=4, channel k = 8'h10+k).
module tb_mux_scan;
  import mux_scan_pkg::*;

  localparam int N_CH  = 8;
  localparam int W     = 8;
  localparam int SEL_W = 3;
  localparam int DWELL = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_CH*W-1:0] din;
  logic [SEL_W-1:0]  sel;
  logic              mode;
  logic [N_CH-1:0]   ch_en;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              out_valid;
  logic              out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_scan #(.N_CH(N_CH), .W(W), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .sel       (sel),
    .mode      (mode),
    .ch_en     (ch_en),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [2:0] c);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".ch"},    32'(out_ch),    32'(c));
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] rr_data [4] = '{8'h12, 8'h15, 8'h17, 8'h10};
  logic [2:0] rr_ch   [4] = '{3'd2, 3'd5, 3'd7, 3'd0};

  initial begin
    rst_n     = 1'b0;
    mode      = MODE_MANUAL;
    sel       = '0;
    ch_en     = '0;
    out_ready = 1'b0;
    for (int k = 0; k < N_CH; k++) din[k*W +: W] = 8'h10 + 8'(k);

    // Reset values.
    #3;
    check_out("rst", 1'b0, 8'h00, 3'd0);
    check("rst.state", 32'(dut.state_q), 32'(MANUAL));
    check("rst.ptr",   32'(dut.ptr_q),   32'd0);
    check("rst.cnt",   32'(dut.cnt_q),   32'd0);

    // Release; the first manual sample appears one cycle later.
    #9 rst_n = 1'b1;
    step(1);
    check_out("first", 1'b1, 8'h10, 3'd0);

    // Manual select with one-cycle latency.
    sel = 3'd3; out_ready = 1'b1;
    step(1);
    check_out("man3", 1'b1, 8'h13, 3'd3);
    sel = 3'd6;
    step(1);
    check_out("man6", 1'b1, 8'h16, 3'd6);

    // Asynchronous reset mid-stream clears outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 8'h00, 3'd0);
    rst_n = 1'b1;
    step(1);
    check_out("post_rst", 1'b1, 8'h16, 3'd6);

    // Scan round-robin over mask 1010_0101, one sample every DWELL cycles.
    mode = MODE_SCAN; ch_en = 8'b1010_0101;
    step(5);
    check_out("rr0", 1'b1, 8'h10, 3'd0);
    for (int i = 0; i < 4; i++) begin
      step(3);
      check("rr_gap.valid", 32'(out_valid), 32'd0);
      step(1);
      check_out($sformatf("rr%0d", i + 1), 1'b1, rr_data[i], rr_ch[i]);
    end

    // Backpressure: stall on ch1 while ch0 is held, then release.
    rst_n = 1'b0;
    #1;
    mode = MODE_SCAN; ch_en = 8'hFF; out_ready = 1'b1;
    #1 rst_n = 1'b1;
    step(5);
    check_out("bp_first", 1'b1, 8'h10, 3'd0);
    out_ready = 1'b0;
    step(10);
    check_out("bp_hold", 1'b1, 8'h10, 3'd0);
    check("bp_hold.state", 32'(dut.state_q), 32'(SCAN_STALL));
    out_ready = 1'b1;
    step(1);
    check_out("bp_release", 1'b1, 8'h11, 3'd1);
    check("bp_release.state", 32'(dut.state_q), 32'(SCAN_DWELL));
    step(4);
    check_out("bp_next", 1'b1, 8'h12, 3'd2);

    // Empty mask: pending sample drains, then nothing until the mask refills.
    out_ready = 1'b0; ch_en = 8'h00;
    step(3);
    check_out("em_pending", 1'b1, 8'h12, 3'd2);
    check("em_pending.cnt", 32'(dut.cnt_q), 32'd0);
    out_ready = 1'b1;
    step(1);
    check("em_drain.valid", 32'(out_valid), 32'd0);
    step(5);
    check("em_idle.valid", 32'(out_valid), 32'd0);
    ch_en = 8'h10;
    step(3);
    check("em_refill_gap.valid", 32'(out_valid), 32'd0);
    step(1);
    check_out("em_ch4", 1'b1, 8'h14, 3'd4);

    // Mask change mid-dwell: current ch4 still sampled, next advance uses new mask.
    ch_en = 8'h04;
    step(4);
    check_out("mid_dwell", 1'b1, 8'h14, 3'd4);

    // Stall on ch2, then switch to manual sel=5; ch2 is never presented.
    out_ready = 1'b0;
    step(4);
    check("ms_stall.state", 32'(dut.state_q), 32'(SCAN_STALL));
    check_out("ms_stall", 1'b1, 8'h14, 3'd4);
    mode = MODE_MANUAL; sel = 3'd5; out_ready = 1'b1;
    step(1);
    check("ms_switch.valid", 32'(out_valid), 32'd0);
    check("ms_switch.state", 32'(dut.state_q), 32'(MANUAL));
    step(1);
    check_out("ms_load", 1'b1, 8'h15, 3'd5);
    step(3);
    check_out("ms_steady", 1'b1, 8'h15, 3'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_scan
